seg_display_arbiter: RTL

Shares the single 8-digit seven-segment display between up to `NUM_REQ` requesters (VGA position readout, debug counters, status codes) and drives the `digit` / `en_dot` / `en_digit` inputs of the seven-segment controller. Ownership is granted round-robin. Each grant is held for a minimum dwell time so that contention does not cause visible flicker. The block runs on the display scan clock, upstream of the seven-segment controller.

---
 rtl/seg_display_arbiter_pkg.sv | 22 ++
 rtl/seg_display_arbiter_rr_pick.sv | 32 +++
 rtl/seg_display_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } seg_arb_state_t;

    localparam logic [7:0] SEG_BLANK_EN = 8'h00;
    localparam int         SEG_MAX_REQ  = 4;

    function automatic logic [31:0] slice32(input logic [32*SEG_MAX_REQ-1:0] vec,
                                            input logic [1:0] idx);
        return vec[32*idx +: 32];
    endfunction

    function automatic logic [7:0] slice8(input logic [8*SEG_MAX_REQ-1:0] vec,
                                          input logic [1:0] idx);
        return vec[8*idx +: 8];
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin picker: first requester after `last`, wrapping; returns `last`
// only when it is the sole requester.
module rr_pick
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = last;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display with minimum dwell.
// Optional digit blinking is compiled in with `define SEG_ARB_BLINK_EN.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 4096,
    parameter int BLINK_HALF  = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [32*NUM_REQ-1:0] req_digit,
    input  logic [8*NUM_REQ-1:0] req_dot,
    input  logic [8*NUM_REQ-1:0] req_en,
`ifdef SEG_ARB_BLINK_EN
    input  logic [7:0]           blink_mask,
`endif
    output logic [NUM_REQ-1:0]   grant,
    output logic                 owner_valid,
    output logic [31:0]          digit,
    output logic [7:0]           en_dot,
    output logic [7:0]           en_digit
);

    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    seg_arb_state_t            state;
    logic [HW-1:0]             hold_cnt;
    logic [1:0]                last;
    logic [7:0]                en_digit_p0;
    logic [NUM_REQ-1:0]        pick_oh;
    logic [1:0]                pick_idx;
    logic [32*SEG_MAX_REQ-1:0] digit_ext;
    logic [8*SEG_MAX_REQ-1:0]  dot_ext;
    logic [8*SEG_MAX_REQ-1:0]  en_ext;
    logic                      owner_req;
    logic                      others_req;
    logic                      hold_done;
    logic                      do_grant;

    assign digit_ext = (32*SEG_MAX_REQ)'(req_digit);
    assign dot_ext   = (8*SEG_MAX_REQ)'(req_dot);
    assign en_ext    = (8*SEG_MAX_REQ)'(req_en);

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (req),
        .last    (last),
        .gnt     (pick_oh),
        .gnt_idx (pick_idx)
    );

    // `last` always names the current owner while OWNED, so it doubles as the data select
    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);
    assign hold_done  = (hold_cnt == '0);
    assign do_grant   = ((state == IDLE) && (|req)) ||
                        ((state == OWNED) && hold_done && others_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= 2'(NUM_REQ - 1);
            hold_cnt    <= '0;
            digit       <= 32'h0;
            en_dot      <= 8'h00;
            en_digit_p0 <= SEG_BLANK_EN;
        end else if (do_grant) begin
            state       <= OWNED;
            grant       <= pick_oh;
            last        <= pick_idx;
            hold_cnt    <= HOLD_LOAD;
            digit       <= slice32(digit_ext, pick_idx);
            en_dot      <= slice8(dot_ext, pick_idx);
            en_digit_p0 <= slice8(en_ext, pick_idx);
        end else if (state == OWNED) begin
            if (!hold_done) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (owner_req) begin
                digit       <= slice32(digit_ext, last);
                en_dot      <= slice8(dot_ext, last);
                en_digit_p0 <= slice8(en_ext, last);
            end else if (hold_done) begin
                state       <= IDLE;
                grant       <= '0;
                en_digit_p0 <= SEG_BLANK_EN;
            end
        end
    end

    assign owner_valid = |grant;

`ifdef SEG_ARB_BLINK_EN
    localparam int            BW         = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (do_grant) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state == OWNED) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign en_digit = blink_off ? (en_digit_p0 & ~blink_mask) : en_digit_p0;
`else
    assign en_digit = en_digit_p0;
`endif

endmodule
